// File: rtl/nor_vector_seq.sv
// nor_vector_seq: exhaustive tester for a 2-input NOR gate.
// Drives the four input vectors 00, 01, 10, 11 on a/b, holds each one for
// SETTLE_CYCLES cycles, samples y for one cycle and counts mismatches
// against ~(a | b).
// Optional feature macro: NOR_VECTOR_SEQ_FAIL_CAPTURE_EN. When it is defined,
// the block records the index and y value of the most recent mismatch.
// When it is undefined, fail_vec and fail_y are tied to 0.
module nor_vector_seq #(
  parameter int SETTLE_CYCLES = 9  // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx,
  output logic [1:0] fail_vec,
  output logic       fail_y
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Final settle count; SETTLE ends on the edge where the counter holds this value.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_s;
  logic [1:0] vec_r;
  logic [1:0] vec_s;
  logic [2:0] err_r;
  logic [2:0] err_s;
  logic       done_r;
  logic       done_s;
  logic       busy_r;
  logic       busy_s;
  logic       pass_r;
  logic       pass_s;
  logic       a_r;
  logic       b_r;
  logic       mismatch_s;

  // The gate output disagrees with the NOR of the vector currently applied.
  assign mismatch_s = (y != ~(a_r | b_r));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and next values for the datapath registers.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    err_s   = err_r;
    done_s  = done_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = SETTLE;
          cnt_s   = 8'd0;
          vec_s   = 2'd0;
          err_s   = 3'd0;
          done_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      SETTLE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = SAMPLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      SAMPLE: begin
        // At most four vectors can mismatch, so the 3-bit count never wraps.
        if (mismatch_s) begin
          err_s = err_r + 3'd1;
        end else begin
          err_s = err_r;
        end
        if (vec_r != 2'd3) begin
          vec_s   = vec_r + 2'd1;
          cnt_s   = 8'd0;
          state_s = SETTLE;
        end else begin
          state_s = DONE;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == SETTLE) || (state_s == SAMPLE);
    pass_s = done_s && (err_s == 3'd0);
  end

  // Datapath registers. a/b follow the vector index, which only moves on
  // start acceptance or on leaving SAMPLE, so a/b stay stable through SETTLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= 8'd0;
      vec_r  <= 2'd0;
      err_r  <= 3'd0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      pass_r <= 1'b0;
      a_r    <= 1'b0;
      b_r    <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      vec_r  <= vec_s;
      err_r  <= err_s;
      done_r <= done_s;
      busy_r <= busy_s;
      pass_r <= pass_s;
      a_r    <= vec_s[1];
      b_r    <= vec_s[0];
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign vec_idx   = vec_r;

`ifdef NOR_VECTOR_SEQ_FAIL_CAPTURE_EN
  logic [1:0] fail_vec_r;
  logic       fail_y_r;
  logic       clear_s;
  logic       capture_s;

  assign clear_s   = ((state_r == IDLE) || (state_r == DONE)) && start;
  assign capture_s = (state_r == SAMPLE) && mismatch_s;

  // Most recent mismatch record, cleared whenever a new run is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_vec_r <= 2'd0;
      fail_y_r   <= 1'b0;
    end else if (clear_s) begin
      fail_vec_r <= 2'd0;
      fail_y_r   <= 1'b0;
    end else if (capture_s) begin
      fail_vec_r <= vec_r;
      fail_y_r   <= y;
    end else begin
      fail_vec_r <= fail_vec_r;
      fail_y_r   <= fail_y_r;
    end
  end

  assign fail_vec = fail_vec_r;
  assign fail_y   = fail_y_r;
`else
  assign fail_vec = 2'b00;
  assign fail_y   = 1'b0;
`endif

endmodule

// File: doc/nor_vector_seq.md
NOR_VECTOR_SEQ -- requirements
Module: nor_vector_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 9: cycles each input vector is held before the gate output is sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin an exhaustive test run; sampled on the rising edge.
REQ-005 a  output  1  first gate input, registered.
REQ-006 b  output  1  second gate input, registered.
REQ-007 y  input  1  gate output under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until the next accepted start.
REQ-010 pass  output  1  equals done AND (err_count == 0).
REQ-011 err_count  output  3  number of mismatching vectors in the current or last run.
REQ-012 vec_idx  output  2  index of the vector currently applied; a = vec_idx[1], b = vec_idx[0].
REQ-013 fail_vec  output  2  index of the most recent mismatching vector (see Configuration).
REQ-014 fail_y  output  1  y value captured at the most recent mismatch (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE; busy = 1 exactly in SETTLE and SAMPLE.
REQ-016 In IDLE or DONE, start = 1 SHALL cause the following:
- enter SETTLE;
- set vec_idx = 0 and a = b = 0;
- clear err_count, done, fail_vec and fail_y;
- load the settle counter with 0.
REQ-017 start SHALL be ignored while busy = 1.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles (counter 0..SETTLE_CYCLES-1, 8 bits), then transition to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and compare y against the expected value ~(a | b); on mismatch, err_count increments by 1.
REQ-020 From SAMPLE with vec_idx < 3: increment vec_idx, update a and b in the same edge, clear the counter, and return to SETTLE.
REQ-021 From SAMPLE with vec_idx == 3: enter DONE and set done = 1; a, b and vec_idx hold their final values.
REQ-022 done SHALL rise exactly 4*(SETTLE_CYCLES+1) rising edges after the edge that accepted start (40 cycles at the default).
REQ-023 err_count SHALL never exceed 4; 3 bits SHALL suffice with no wrap.
REQ-024 a and b SHALL change only on the edges defined in REQ-016 and REQ-020; they SHALL never change during SETTLE.

Reset
REQ-025 When reset_n = 0, regardless of clk, the block SHALL immediately enter IDLE with every output at 0:
- a, b, busy, done, pass;
- err_count, vec_idx, fail_vec, fail_y.
REQ-026 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-027 After reset_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Configuration
REQ-028 Macro NOR_VECTOR_SEQ_FAIL_CAPTURE_EN, when defined, SHALL enable fail capture: on each SAMPLE mismatch, fail_vec <= vec_idx and fail_y <= y.
REQ-029 When the macro is undefined, fail_vec and fail_y SHALL be present and tied to 0, and no capture registers SHALL be instantiated; all other behaviour is unchanged.

Verification
REQ-030 Correct NOR model on y, default SETTLE_CYCLES, start pulse -> done = 1 after 40 cycles; pass = 1, err_count = 0; a/b sequence 00, 01, 10, 11.
REQ-031 y stuck at 0 -> err_count = 1, pass = 0; with the macro defined, fail_vec = 0 and fail_y = 0.
REQ-032 y stuck at 1 -> err_count = 3; with the macro defined, fail_vec = 3 and fail_y = 1.
REQ-033 start pulsed again at cycle 15 of a run -> ignored; done still rises at cycle 40 and vec_idx progresses normally.
REQ-034 reset_n pulled low while vec_idx = 2 -> all outputs 0 immediately (async); a new start then produces a full 40-cycle run with a correct result.
REQ-035 SETTLE_CYCLES = 1, start issued from DONE -> done clears on the accepting edge and rises again 8 cycles later; err_count is recomputed from 0.
